// File: rtl/resolvedor_tiro.sv
// Shot resolver: scans the target player's ship records, classifies the shot
// (hit / miss / repeat / invalid) and writes back the record on a new hit.
module resolvedor_tiro #(
  parameter int N_ENTRADAS    = 11,
  parameter int TAM_TABULEIRO = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  tiro_x,
  input  logic [3:0]  tiro_y,
  input  logic        jogador,
  input  logic [63:0] vetor_leitura,
  output logic [4:0]  read_addr,
  output logic [4:0]  write_addr,
  output logic [63:0] vetor,
  output logic        wrep1,
  output logic        wrep2,
  output logic        busy,
  output logic        ready,
  output logic        acerto,
  output logic        agua,
  output logic        repetido,
  output logic        invalido,
  output logic        afundou,
  output logic [2:0]  tipo_afundado,
  output logic        frota_destruida
);

  localparam logic [4:0] ULTIMO = 5'(N_ENTRADAS - 1);
  localparam logic [3:0] TAM    = 4'(TAM_TABULEIRO);

  typedef enum logic [2:0] {IDLE, LE, COMPARA, ESCREVE, FIM} estado_t;
  estado_t estado, prox;

  logic [4:0]  idx;
  logic [3:0]  x_r, y_r;
  logic        jog_r;
  logic        all_zero;

  logic [2:0]  n_cel;
  logic        casou, ativo, marcado, novo_acerto;
  logic [2:0]  cel_k;
  logic [3:0]  rem, rem_pos;
  logic [63:0] vetor_novo;
  logic        tiro_fora;

  assign tiro_fora = (tiro_x >= TAM) || (tiro_y >= TAM);
  assign read_addr = idx;
  assign wrep1     = (estado == ESCREVE) && !jog_r;
  assign wrep2     = (estado == ESCREVE) &&  jog_r;

  // Record decode: first valid cell matching the captured coordinates wins.
  always_comb begin
    case (vetor_leitura[2:0])
      3'd0:    n_cel = 3'd5;
      3'd1:    n_cel = 3'd4;
      3'd2:    n_cel = 3'd3;
      3'd3:    n_cel = 3'd2;
      3'd4:    n_cel = 3'd1;
      default: n_cel = 3'd0;
    endcase
    casou = 1'b0;
    cel_k = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!casou && (k < int'(n_cel)) &&
          vetor_leitura[3+8*k +: 4] == x_r && vetor_leitura[7+8*k +: 4] == y_r) begin
        casou = 1'b1;
        cel_k = 3'(k);
      end
    end
    rem         = vetor_leitura[46:43];
    ativo       = (rem != 4'd0);
    marcado     = vetor_leitura[47 + int'(cel_k)];
    novo_acerto = ativo && casou && !marcado;
    rem_pos     = novo_acerto ? rem - 4'd1 : rem;
    vetor_novo  = vetor_leitura;
    vetor_novo[47 + int'(cel_k)] = 1'b1;
    vetor_novo[46:43] = rem - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      IDLE:    if (start) prox = tiro_fora ? FIM : LE;
      LE:      prox = COMPARA;
      COMPARA: if (novo_acerto)        prox = ESCREVE;
               else if (idx == ULTIMO) prox = FIM;
               else                    prox = LE;
      ESCREVE: prox = (idx == ULTIMO) ? FIM : LE;
      FIM:     prox = IDLE;
      default: prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      x_r             <= '0;
      y_r             <= '0;
      jog_r           <= 1'b0;
      all_zero        <= 1'b0;
      write_addr      <= '0;
      vetor           <= '0;
      busy            <= 1'b0;
      ready           <= 1'b0;
      acerto          <= 1'b0;
      agua            <= 1'b0;
      repetido        <= 1'b0;
      invalido        <= 1'b0;
      afundou         <= 1'b0;
      tipo_afundado   <= '0;
      frota_destruida <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (estado)
        IDLE: if (start) begin
          x_r             <= tiro_x;
          y_r             <= tiro_y;
          jog_r           <= jogador;
          idx             <= '0;
          all_zero        <= 1'b1;
          busy            <= 1'b1;
          acerto          <= 1'b0;
          agua            <= 1'b0;
          repetido        <= 1'b0;
          invalido        <= tiro_fora;
          afundou         <= 1'b0;
          tipo_afundado   <= '0;
          frota_destruida <= 1'b0;
        end
        COMPARA: begin
          all_zero <= all_zero && (rem_pos == 4'd0);
          if (ativo && casou && marcado) repetido <= 1'b1;
          if (novo_acerto) begin
            acerto     <= 1'b1;
            write_addr <= idx;
            vetor      <= vetor_novo;
          end else if (idx != ULTIMO) begin
            idx <= idx + 5'd1;
          end
        end
        ESCREVE: begin
          if (vetor[46:43] == 4'd0) begin
            afundou       <= 1'b1;
            tipo_afundado <= vetor[2:0];
          end
          if (idx != ULTIMO) idx <= idx + 5'd1;
        end
        FIM: begin
          agua            <= !(acerto || repetido || invalido);
          frota_destruida <= all_zero && !invalido;
          ready           <= 1'b1;
          busy            <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resolvedor_tiro.sv
// Directed bench for resolvedor_tiro with two behavioural record memories.
module tb_resolvedor_tiro;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  tiro_x = '0, tiro_y = '0;
  logic        jogador = 1'b0;
  logic [63:0] vetor_leitura = '0;
  logic [4:0]  read_addr, write_addr;
  logic [63:0] vetor;
  logic        wrep1, wrep2, busy, ready;
  logic        acerto, agua, repetido, invalido, afundou, frota_destruida;
  logic [2:0]  tipo_afundado;

  resolvedor_tiro dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tiro_x(tiro_x), .tiro_y(tiro_y),
    .jogador(jogador), .vetor_leitura(vetor_leitura), .read_addr(read_addr),
    .write_addr(write_addr), .vetor(vetor), .wrep1(wrep1), .wrep2(wrep2),
    .busy(busy), .ready(ready), .acerto(acerto), .agua(agua), .repetido(repetido),
    .invalido(invalido), .afundou(afundou), .tipo_afundado(tipo_afundado),
    .frota_destruida(frota_destruida)
  );

  always #5 clk = ~clk;

  logic [63:0] mem1 [0:10];
  logic [63:0] mem2 [0:10];
  logic        sel = 1'b0;
  int          wr1 = 0, wr2 = 0;
  logic [4:0]  last_waddr = '0;
  logic [63:0] last_vetor = '0;
  int          total = 0, bad = 0;

  always @(posedge clk) begin
    vetor_leitura <= sel ? mem2[read_addr] : mem1[read_addr];
    if (wrep1) mem1[write_addr] <= vetor;
    if (wrep2) mem2[write_addr] <= vetor;
  end

  always @(negedge clk) begin
    if (wrep1) wr1++;
    if (wrep2) wr2++;
    if (wrep1 || wrep2) begin
      last_waddr = write_addr;
      last_vetor = vetor;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rec(input logic [2:0] tipo, input int x0, input int y0,
                                      input bit horiz, input int n, input int remaining);
    logic [63:0] r;
    r = '0;
    r[2:0] = tipo;
    for (int k = 0; k < n; k++) begin
      r[3+8*k +: 4] = 4'(horiz ? x0 + k : x0);
      r[7+8*k +: 4] = 4'(horiz ? y0 : y0 + k);
    end
    r[46:43] = 4'(remaining);
    return r;
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 11; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
  endtask

  task automatic shoot(input logic [3:0] x, input logic [3:0] y, input logic j,
                       input bit glitch, output int lat);
    @(negedge clk);
    sel = j; tiro_x = x; tiro_y = y; jogador = j; start = 1'b1;
    wr1 = 0; wr2 = 0;
    @(posedge clk);
    #1;
    start = 1'b0; tiro_x = 4'd0; tiro_y = 4'd0; jogador = ~j;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      start = glitch && (lat == 5);
      if (ready) break;
    end
    start = 1'b0;
  endtask

  int lat;
  logic [63:0] orig, expv;

  initial begin
    clear_mems();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_wrep", {wrep1, wrep2}, 0);
    chk("rst_addr", {read_addr, write_addr}, 0);
    chk("rst_vetor", vetor, 0);
    chk("rst_flags", {acerto, agua, repetido, invalido, afundou, tipo_afundado, frota_destruida}, 0);
    rst_n = 1'b1;

    // tipo 0 horizontal at (2,3): shot (4,3) hits cell 2
    orig = rec(3'd0, 2, 3, 1'b1, 5, 5);
    mem1[0] = orig;
    expv = orig;
    expv[49] = 1'b1;
    expv[46:43] = 4'd4;
    shoot(4'd4, 4'd3, 1'b0, 1'b0, lat);
    chk("hit_lat", lat, 24);
    chk("hit_flags", {acerto, agua, repetido, invalido, afundou}, 5'b10000);
    chk("hit_wr1", wr1, 1);
    chk("hit_wr2", wr2, 0);
    chk("hit_waddr", last_waddr, 0);
    chk("hit_vetor", last_vetor, expv);
    chk("hit_mem", mem1[0], expv);
    chk("hit_frota", frota_destruida, 0);
    chk("hit_busy", busy, 0);
    @(posedge clk); #1;
    chk("ready_pulse", ready, 0);

    // repeat shot, with a start pulse while busy that must be ignored
    shoot(4'd4, 4'd3, 1'b0, 1'b1, lat);
    chk("rep_lat", lat, 23);
    chk("rep_flags", {acerto, agua, repetido, invalido}, 4'b0010);
    chk("rep_wr", wr1 + wr2, 0);
    @(posedge clk); #1;
    chk("rep_ignored_start", busy, 0);

    // empty player-2 memory
    shoot(4'd0, 4'd0, 1'b1, 1'b0, lat);
    chk("empty_lat", lat, 23);
    chk("empty_flags", {acerto, agua, repetido, invalido}, 4'b0100);
    chk("empty_wr", wr1 + wr2, 0);
    chk("empty_frota", frota_destruida, 1);

    // single tipo 4 at (7,7) in record 5 sinks the fleet
    mem2[5] = rec(3'd4, 7, 7, 1'b1, 1, 1);
    shoot(4'd7, 4'd7, 1'b1, 1'b0, lat);
    chk("sink_lat", lat, 24);
    chk("sink_wr2", wr2, 1);
    chk("sink_wr1", wr1, 0);
    chk("sink_waddr", last_waddr, 5);
    chk("sink_flags", {acerto, afundou, tipo_afundado, frota_destruida}, {1'b1, 1'b1, 3'd4, 1'b1});

    // tipo 3 at (1,1),(2,1): empty cells at (0,0) must not match
    clear_mems();
    mem1[2] = rec(3'd3, 1, 1, 1'b1, 2, 2);
    shoot(4'd0, 4'd0, 1'b0, 1'b0, lat);
    chk("t3_agua", {acerto, agua, repetido, invalido}, 4'b0100);
    chk("t3_frota", frota_destruida, 0);
    chk("t3_wr", wr1 + wr2, 0);
    shoot(4'd2, 4'd1, 1'b0, 1'b0, lat);
    chk("t3_hit", {acerto, afundou, frota_destruida}, 3'b100);
    chk("t3_waddr", last_waddr, 2);
    shoot(4'd10, 4'd2, 1'b0, 1'b0, lat);
    chk("inv_lat", lat, 1);
    chk("inv_flags", {acerto, agua, repetido, invalido, frota_destruida}, 5'b00010);
    chk("inv_wr", wr1 + wr2, 0);

    // reset mid-scan
    @(negedge clk);
    sel = 1'b0; tiro_x = 4'd1; tiro_y = 4'd1; jogador = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstscan_busy", busy, 0);
    chk("rstscan_addr", read_addr, 0);
    chk("rstscan_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset during the write cycle: wrep drops at once and memory keeps its value
    orig = mem1[2];
    @(negedge clk);
    sel = 1'b0; tiro_x = 4'd1; tiro_y = 4'd1; jogador = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!wrep1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("wr_reached", wrep1, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("rstwr_wrep", {wrep1, wrep2}, 0);
    chk("rstwr_out", {busy, ready, write_addr, acerto}, 0);
    chk("rstwr_vetor", vetor, 0);
    @(negedge clk); @(negedge clk);
    chk("rstwr_mem", mem1[2], orig);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/resolvedor_tiro.md
# resolvedor_tiro

Shot resolver for the naval battle game: the reader/updater of the ship-record memory that the placement validator fills. On a shot request it scans all 11 ship records of the target player, detects hit, miss or repeat, writes back the updated record on a new hit, and reports sunk ship and fleet-destroyed status. It sits between the game-control FSM (shot issuer) and the two per-player record memories.

## Interface
- N_ENTRADAS, 11, records per player memory (addresses 0..N_ENTRADAS-1)
- TAM_TABULEIRO, 10, board side; legal coordinates 0..TAM_TABULEIRO-1
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  shot request, sampled only while idle
- tiro_x, tiro_y  in  4 each  shot coordinates, captured on accepted start
- jogador  in  1  target memory: 0 = player 1, 1 = player 2; captured on start
- vetor_leitura  in  64  record read data, valid the cycle after read_addr is driven
- read_addr  out  5  record read address
- write_addr  out  5  record write address
- vetor  out  64  record write data
- wrep1, wrep2  out  1 each  write enables for player-1 / player-2 memory
- busy  out  1  high from accepted start until ready
- ready  out  1  one-cycle completion pulse
- acerto, agua, repetido, invalido  out  1 each  shot result flags (exactly one high after ready)
- afundou  out  1  this shot sank a ship
- tipo_afundado  out  3  tipo of sunk ship (valid when afundou)
- frota_destruida  out  1  every record of target player has remaining count 0

## Operation
- Record layout: [2:0] tipo; cell k (k=0..4) x at [6+8k -: 4], y at [10+8k -: 4]; [46:43] remaining pieces; [51:47] hit mask (bit 47+k = cell k hit); [63:52] zero. Writer leaves mask 0.
- Cells valid per tipo: 0→5, 1→4, 2→3, 3→2, 4→1; tipo 5..7 → 0 cells. Only valid cells compared (empty cells are 0,0 and must not match).
- Record with remaining==0 is skipped (unwritten or sunk).
- States: IDLE, LE, COMPARA, ESCREVE, FIM.
- IDLE: start=1 → capture x, y, jogador, clear flags, idx=0, busy=1; if x or y ≥ TAM_TABULEIRO → FIM with invalido=1, else LE.
- LE: read_addr=idx → COMPARA.
- COMPARA: evaluate vetor_leitura. First matching valid cell only (placement guarantees no overlap). Match with mask bit set → repetido=1. Match with bit clear → acerto=1, build vetor = record with bit set and remaining−1 (4-bit, never underflows since remaining≥1), write_addr=idx → ESCREVE. Track all_zero &= (post-update remaining==0). No write → idx==N_ENTRADAS-1 ? FIM : idx+1, LE.
- ESCREVE: exactly one of wrep1/wrep2 high (by captured jogador) for one cycle; if new remaining==0 → afundou=1, tipo_afundado=tipo. Then continue scan as above.
- FIM: agua=1 if no flag set; frota_destruida=all_zero (0 for invalido); ready=1 one cycle; busy=0 → IDLE.
- Result flags, afundou, tipo_afundado, frota_destruida hold until next accepted start.
- start while busy: ignored. Inputs other than vetor_leitura ignored after capture.

## Timing
- Reset (async, rst_n=0): state IDLE; all outputs 0 (read_addr, write_addr, vetor, wrep1, wrep2, busy, ready, all flags, tipo_afundado). wrep deassert immediately; a write in flight is aborted.
- Start accepted at edge E0. Scan: 2 cycles per record; valid shot → ready high in cycle after edge E0+2·N_ENTRADAS+1 (23 for default), +1 cycle if a write occurred (24). Invalid shot → ready after E0+1.
- At most one write per shot; wrep high exactly one cycle, write_addr/vetor stable that cycle.
- start may be re-asserted in the cycle ready is high; it is accepted on the following edge (IDLE).
- idx never exceeds N_ENTRADAS-1; read_addr wraps to 0 only on next shot.

## Test plan
- Record 0 = tipo 0 horizontal at (2,3), remaining 5; shot (4,3) jogador 0 → ready at 24, acerto=1, wrep1 one cycle, write_addr=0, vetor[46:43]=4, bit 49 set, wrep2=0.
- Repeat shot (4,3) → repetido=1, no wrep, ready at 23.
- Memory all zero, shot (0,0) jogador 1 → agua=1, no write, frota_destruida=1.
- Only record 5 = tipo 4 at (7,7) remaining 1; shot (7,7) jogador 1 → wrep2, write_addr=5, afundou=1, tipo_afundado=4, frota_destruida=1.
- tipo 3 at (1,1),(2,1), remaining 2; shot (0,0) → agua (empty cells ignored); shot (10,2) → invalido=1, ready next cycle.
- rst_n low mid-scan and during ESCREVE → all outputs 0 immediately, no wrep; start while busy ignored.
